// File: rtl/aquila_wb_pkg.sv
// Shared definitions for the Aquila device-port to Wishbone pipelined bridge:
// FSM state encoding, error read-data default and timeout counter sizing.
package aquila_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam int          TIMEOUT_DEFAULT  = 255;

  // A disabled timeout (0) still gets a 1-bit counter so the ports stay legal.
  function automatic int to_cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/core2wb_pipe_bridge.sv
// Aquila device-port to Wishbone B4 pipelined master, one transaction in flight,
// with stall handshake, error/timeout termination and registered outputs.
module core2wb_pipe_bridge
  import aquila_wb_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              AW       = 2,
  parameter int              DW       = 32,
  parameter int              TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [XLEN-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              S_DEVICE_strobe_i,
  input  logic [XLEN-1:0]   S_DEVICE_addr_i,
  input  logic              S_DEVICE_rw_i,
  input  logic [XLEN/8-1:0] S_DEVICE_byte_enable_i,
  input  logic [XLEN-1:0]   S_DEVICE_data_i,
  output logic              S_DEVICE_data_ready_o,
  output logic [XLEN-1:0]   S_DEVICE_data_o,
  output logic              S_DEVICE_err_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW-1:0]     wb_data_o,
  output logic [DW/8-1:0]   wb_sel_o,
  input  logic              wb_stall_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic [DW-1:0]     wb_data_i,
  output wb_state_e         dbg_state_o
);

  localparam int              CNT_W    = to_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Handshake: the core pulses strobe only in IDLE and waits for the single
  // data_ready pulse; on Wishbone a strobe is accepted on the first cycle with
  // stb=1 and stall=0, and ack/err (err wins) terminates from REQ or WAIT.

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [DW/8-1:0]   sel_q;
  logic [DW-1:0]     wdata_q;
  logic              load_req;
  logic              fin;
  logic              fin_err;
  logic              timeout_hit;

  // Only the word-address bits take part; byte offset and upper bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_DEVICE_addr_i[XLEN-1:AW+2], S_DEVICE_addr_i[1:0]};

  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    load_req = 1'b0;
    fin      = 1'b0;
    fin_err  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (S_DEVICE_strobe_i) begin
          load_req = 1'b1;
          state_d  = ST_REQ;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
        end
      end
      ST_REQ: begin
        if (wb_ack_i || wb_err_i) begin
          fin     = 1'b1;
          fin_err = wb_err_i;
        end else if (!wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wb_ack_i || wb_err_i) begin
          fin     = 1'b1;
          fin_err = wb_err_i;
        end else if (timeout_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase

    if (fin) begin
      state_d = ST_RESP;
      cnt_d   = '0;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      ready_d = 1'b1;
      err_d   = fin_err;
      if (fin_err)    rdata_d = ERR_DATA;
      else if (we_q)  rdata_d = '0;
      else            rdata_d = wb_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (load_req) begin
        we_q    <= S_DEVICE_rw_i;
        addr_q  <= S_DEVICE_addr_i[AW+1:2];
        sel_q   <= S_DEVICE_byte_enable_i;
        wdata_q <= S_DEVICE_data_i;
      end
    end
  end

  assign S_DEVICE_data_ready_o = ready_q;
  assign S_DEVICE_data_o       = rdata_q;
  assign S_DEVICE_err_o        = err_q;
  assign wb_cyc_o              = cyc_q;
  assign wb_stb_o              = stb_q;
  assign wb_we_o               = we_q;
  assign wb_addr_o             = addr_q;
  assign wb_data_o             = wdata_q;
  assign wb_sel_o              = sel_q;
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_core2wb_pipe_bridge.sv
// Directed bench for core2wb_pipe_bridge: hand-timed Wishbone slave responses,
// expected completions queued and checked at the data_ready cycle.
module tb_core2wb_pipe_bridge;
  import aquila_wb_pkg::*;

  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        strobe;
  logic [31:0] addr;
  logic        rw;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        cyc, stb, we;
  logic [1:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  sel;
  logic        stall, ack, err;
  logic [31:0] slv_data;
  wb_state_e   state;

  core2wb_pipe_bridge #(
    .XLEN(32), .AW(2), .DW(32), .TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .S_DEVICE_strobe_i      (strobe),
    .S_DEVICE_addr_i        (addr),
    .S_DEVICE_rw_i          (rw),
    .S_DEVICE_byte_enable_i (be),
    .S_DEVICE_data_i        (wdata),
    .S_DEVICE_data_ready_o  (ready),
    .S_DEVICE_data_o        (rdata_o),
    .S_DEVICE_err_o         (err_o),
    .wb_cyc_o               (cyc),
    .wb_stb_o               (stb),
    .wb_we_o                (we),
    .wb_addr_o              (wb_addr),
    .wb_data_o              (wb_wdata),
    .wb_sel_o               (sel),
    .wb_stall_i             (stall),
    .wb_ack_i               (ack),
    .wb_err_i               (err),
    .wb_data_i              (slv_data),
    .dbg_state_o            (state)
  );

  // ---------------- scoreboard ----------------
  int          n_vec   = 0;
  int          n_miss  = 0;
  int          n_ready = 0;
  logic [32:0] exp_q[$];   // {err, data}

  // Counts data_ready pulses seen in the cycle before each rising edge.
  always @(posedge clk) if (ready) n_ready++;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_resp(input string tag);
    logic [32:0] e;
    check_vec({tag, "_ready"}, 64'(ready), 64'd1);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_sb: got completion expected none pending", tag);
    end else begin
      e = exp_q.pop_front();
      check_vec({tag, "_data"}, 64'(rdata_o), 64'(e[31:0]));
      check_vec({tag, "_err"}, 64'(err_o), 64'(e[32]));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d);
    if (state != ST_IDLE)
      $display("note: strobe_i raised while bridge busy (protocol violation, must be ignored)");
    strobe = 1'b1;
    addr   = a;
    rw     = w;
    be     = b;
    wdata  = d;
    tick();
    strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int r0;
    int n;
    int cyc_low;
    strobe = 0; addr = 0; rw = 0; be = 0; wdata = 0;
    stall = 0; ack = 0; err = 0; slv_data = 0;

    // Reset state
    repeat (3) tick();
    check_vec("rst_ctrl", 64'({cyc, stb, we, ready, err_o}), 64'd0);
    check_vec("rst_fields", 64'({wb_addr, sel}), 64'd0);
    check_vec("rst_data", 64'({rdata_o, wb_wdata}), 64'd0);
    check_vec("rst_state", 64'(state), 64'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // T1: read 0x8, zero-stall, ack at T1 -> data_ready at T2
    exp_q.push_back({1'b0, 32'h1234_5678});
    issue(32'h0000_0008, 1'b0, 4'hF, 32'h0);
    check_vec("t1_cyc_stb_we", 64'({cyc, stb, we}), 64'b110);
    check_vec("t1_addr", 64'(wb_addr), 64'd2);
    ack = 1; slv_data = 32'h1234_5678;
    tick();
    ack = 0; slv_data = 0;
    check_resp("t1");
    check_vec("t1_cyc_drop", 64'({cyc, stb}), 64'd0);
    tick();
    check_vec("t1_ready_pulse", 64'(ready), 64'd0);

    // T2: write 0xC, be=0011, stall held for 3 cycles -> stb high 4 cycles
    r0 = n_ready;
    stall = 1;
    exp_q.push_back({1'b0, 32'h0});
    issue(32'h0000_000C, 1'b1, 4'b0011, 32'hAABB_CCDD);
    for (int i = 0; i < 4; i++) begin
      check_vec($sformatf("t2_stb%0d", i), 64'({cyc, stb, we}), 64'b111);
      check_vec($sformatf("t2_addr%0d", i), 64'(wb_addr), 64'd3);
      check_vec($sformatf("t2_sel%0d", i), 64'(sel), 64'b0011);
      check_vec($sformatf("t2_wdata%0d", i), 64'(wb_wdata), 64'hAABB_CCDD);
      if (i == 3) stall = 0;
      tick();
    end
    check_vec("t2_wait", 64'({cyc, stb}), 64'b10);
    ack = 1; slv_data = 32'h9999_9999;
    tick();
    ack = 0; slv_data = 0;
    check_resp("t2");
    tick();
    check_vec("t2_ready_pulse", 64'(ready), 64'd0);
    tick();
    check_vec("t2_one_ready", 64'(n_ready - r0), 64'd1);

    // T3: slave error instead of ack on a read
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    issue(32'h0000_0004, 1'b0, 4'hF, 32'h0);
    err = 1; slv_data = 32'h5555_5555;
    tick();
    err = 0; slv_data = 0;
    check_resp("t3");
    check_vec("t3_cyc_drop", 64'({cyc, stb}), 64'd0);
    tick();

    // T4: slave never answers -> timeout 8 edges after acceptance
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    issue(32'h0000_0000, 1'b0, 4'hF, 32'h0);
    n = 0;
    cyc_low = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
      if (!ready && !cyc) cyc_low++;
    end
    // acceptance edge follows this negedge; pulse visible 8 edges later
    check_vec("t4_latency", 64'(n), 64'(TO + 1));
    check_vec("t4_cyc_held", 64'(cyc_low), 64'd0);
    check_vec("t4_cyc_drop", 64'(cyc), 64'd0);
    check_resp("t4");
    tick();
    // follow-up read; unused address bits must be dropped
    exp_q.push_back({1'b0, 32'hCAFE_F00D});
    issue(32'hFFFF_FFF7, 1'b0, 4'hF, 32'h0);
    check_vec("t4n_addr", 64'(wb_addr), 64'd1);
    ack = 1; slv_data = 32'hCAFE_F00D;
    tick();
    ack = 0; slv_data = 0;
    check_resp("t4n");
    tick();

    // T5: asynchronous reset while in WAIT
    r0 = n_ready;
    issue(32'h0000_0008, 1'b0, 4'hF, 32'h0);
    tick();
    check_vec("t5_in_wait", 64'({cyc, stb, state}), 64'({1'b1, 1'b0, ST_WAIT}));
    #2 rst_n = 1'b0;
    #1;
    check_vec("t5_async_ctrl", 64'({cyc, stb, ready}), 64'd0);
    check_vec("t5_async_state", 64'(state), 64'(ST_IDLE));
    ack = 1; slv_data = 32'h7777_7777;
    tick();
    tick();
    ack = 0; slv_data = 0;
    rst_n = 1'b1;
    tick();
    tick();
    check_vec("t5_no_ready", 64'(n_ready - r0), 64'd0);
    exp_q.push_back({1'b0, 32'h0F0F_0F0F});
    issue(32'h0000_000C, 1'b0, 4'hF, 32'h0);
    check_vec("t5_addr", 64'(wb_addr), 64'd3);
    tick();
    ack = 1; slv_data = 32'h0F0F_0F0F;
    tick();
    ack = 0; slv_data = 0;
    check_resp("t5");
    tick();

    // T6: back-to-back issue, then a stray strobe during WAIT
    exp_q.push_back({1'b0, 32'h1111_1111});
    issue(32'h0000_0000, 1'b0, 4'hF, 32'h0);
    ack = 1; slv_data = 32'h1111_1111;
    tick();
    ack = 0; slv_data = 0;
    check_resp("t6a");
    tick();
    exp_q.push_back({1'b0, 32'h2222_2222});
    issue(32'h0000_0004, 1'b0, 4'hF, 32'h0);
    check_vec("t6_b2b_stb", 64'({cyc, stb}), 64'b11);
    check_vec("t6_b2b_addr", 64'(wb_addr), 64'd1);
    r0 = n_ready;
    tick();
    issue(32'h0000_0008, 1'b1, 4'h1, 32'h3333_3333);
    check_vec("t6_ignored_fields", 64'({we, wb_addr}), 64'({1'b0, 2'd1}));
    ack = 1; slv_data = 32'h2222_2222;
    tick();
    ack = 0; slv_data = 0;
    check_resp("t6b");
    tick();
    check_vec("t6_ready_pulse", 64'(ready), 64'd0);
    tick();
    check_vec("t6_no_phantom", 64'({cyc, stb, state}), 64'({1'b0, 1'b0, ST_IDLE}));
    check_vec("t6_one_ready", 64'(n_ready - r0), 64'd1);

    // Stray ack in IDLE
    ack = 1; slv_data = 32'h4444_4444;
    tick();
    ack = 0; slv_data = 0;
    tick();
    check_vec("stray_ack", 64'({ready, cyc, stb}), 64'd0);
    check_vec("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
